// File: rtl/mem_req_adapter.sv
// mem_req_adapter: valid/ready request front-end for a 64-bit word SRAM with a
// W0 write port and an R0 read port. Requests become single-cycle SRAM strobes.
// In-order responses (including read data) are returned through a credit-limited
// response FIFO, so a stalled consumer never loses read data.
module mem_req_adapter #(
  parameter int          ADDR_W     = 28,
  parameter int          DATA_W     = 64,
  parameter int          ID_W       = 4,
  parameter int          MASK_W     = DATA_W / 8,
  parameter logic [63:0] BASE_ADDR  = 64'h8000_0000,
  parameter int          RESP_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  // request stream
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [63:0]       req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic [MASK_W-1:0] req_mask,
  input  logic [ID_W-1:0]   req_id,
  // response stream
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_write,
  output logic              resp_err,
  output logic [DATA_W-1:0] resp_data,
  output logic [ID_W-1:0]   resp_id,
  // SRAM write port
  output logic              W0_en,
  output logic [ADDR_W-1:0] W0_addr,
  output logic [DATA_W-1:0] W0_data,
  output logic [MASK_W-1:0] W0_mask,
  // SRAM read port
  output logic              R0_en,
  output logic [ADDR_W-1:0] R0_addr,
  input  logic [DATA_W-1:0] R0_data
);

  localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RESP_DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;

  typedef struct packed {
    logic              write;
    logic              err;
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
  } resp_t;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [63:0] off;
  logic        below_base;
  logic        out_of_range;
  logic        misaligned;
  logic        fault;

  assign off          = req_addr - BASE_ADDR;
  assign below_base   = (req_addr < BASE_ADDR);
  assign out_of_range = |off[63:ADDR_W+3];
  // BASE_ADDR maps to word 0, so it is word aligned and off[2:0] == req_addr[2:0].
  assign misaligned   = |off[2:0];
  assign fault        = below_base | out_of_range | misaligned;

  // ---------------------------------------------------------------------------
  // Credits: every accepted request owns a slot until its response is consumed.
  // Only registered state feeds req_ready; reset_n forces it low during reset.
  // ---------------------------------------------------------------------------
  logic             s1_valid_q;
  logic             s1_write_q;
  logic             s1_err_q;
  logic [ID_W-1:0]  s1_id_q;
  logic             s1_is_read_q;
  logic [CNT_W-1:0] count_q, count_d, count_after_deq;
  logic [OCC_W-1:0] occ;
  logic             fire;

  assign occ       = OCC_W'(count_q) + OCC_W'(s1_valid_q);
  assign req_ready = reset_n && (occ < OCC_W'(RESP_DEPTH));
  assign fire      = req_valid && req_ready;

  // SRAM strobes are purely combinational in the accept cycle.
  assign W0_en   = fire && req_write && !fault;
  assign W0_addr = off[ADDR_W+2:3];
  assign W0_data = req_data;
  assign W0_mask = req_mask;
  assign R0_en   = fire && !req_write && !fault;
  assign R0_addr = off[ADDR_W+2:3];

  // Stage 1: remember what was accepted while the SRAM read is in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q   <= 1'b0;
      s1_write_q   <= 1'b0;
      s1_err_q     <= 1'b0;
      s1_id_q      <= '0;
      s1_is_read_q <= 1'b0;
    end else begin
      s1_valid_q   <= fire;
      s1_write_q   <= req_write;
      s1_err_q     <= fault;
      s1_id_q      <= req_id;
      s1_is_read_q <= fire && !req_write && !fault;
    end
  end

  // ---------------------------------------------------------------------------
  // Response FIFO. The head entry is mirrored into output registers, and that
  // entry stays counted in count_q until it is consumed.
  // ---------------------------------------------------------------------------
  resp_t            mem_q [RESP_DEPTH];
  resp_t            enq_entry;
  resp_t            resp_q, resp_d;
  logic             resp_valid_q, resp_valid_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             enq;
  logic             deq;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign enq = s1_valid_q;
  assign deq = (count_q != '0) && resp_ready;

  // R0_data is sampled here, one cycle after R0_en, and frozen into the FIFO.
  assign enq_entry = '{write: s1_write_q,
                       err:   s1_err_q,
                       id:    s1_id_q,
                       data:  s1_is_read_q ? R0_data : '0};

  // Next pointers, count and the entry that will be presented next cycle.
  always_comb begin
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    count_after_deq = count_q - CNT_W'(deq);
    count_d         = count_after_deq + CNT_W'(enq);
    resp_d          = '0;
    resp_valid_d    = (count_d != '0);
    if (enq) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (deq) rd_ptr_d = ptr_inc(rd_ptr_q);
    if (count_after_deq != '0) begin
      resp_d = mem_q[rd_ptr_d];
    end else if (enq) begin
      // Queue drains this cycle: the new entry becomes the head directly.
      resp_d = enq_entry;
    end
  end

  // FIFO storage write; contents need no reset since count_q gates visibility.
  always_ff @(posedge clock) begin
    if (enq) mem_q[wr_ptr_q] <= enq_entry;
  end

  // FIFO control and registered response outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_q       <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      resp_valid_q <= resp_valid_d;
      resp_q       <= resp_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_write = resp_q.write;
  assign resp_err   = resp_q.err;
  assign resp_data  = resp_q.data;
  assign resp_id    = resp_q.id;

  // The credit rule makes overflow unreachable; flag it loudly if it ever happens.
  fifo_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
    !(enq && !deq && (count_q == CNT_W'(RESP_DEPTH))));

endmodule

// File: tb/tb_mem_req_adapter.sv
// Bench for mem_req_adapter: directed scenarios followed by random traffic, all
// checked cycle by cycle against a transaction-level model of the adapter.
module tb_mem_req_adapter;

  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam logic [63:0] SPAN  = 64'd1 << 31;
  localparam int          DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_write;
  logic [63:0] req_addr, req_data;
  logic [7:0]  req_mask;
  logic [3:0]  req_id;
  logic        resp_valid, resp_ready, resp_write, resp_err;
  logic [63:0] resp_data;
  logic [3:0]  resp_id;
  logic        W0_en, R0_en;
  logic [27:0] W0_addr, R0_addr;
  logic [63:0] W0_data, R0_data;
  logic [7:0]  W0_mask;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_accepted = 0;

  mem_req_adapter dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_data(req_data), .req_mask(req_mask), .req_id(req_id),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_write(resp_write),
    .resp_err(resp_err), .resp_data(resp_data), .resp_id(resp_id),
    .W0_en(W0_en), .W0_addr(W0_addr), .W0_data(W0_data), .W0_mask(W0_mask),
    .R0_en(R0_en), .R0_addr(R0_addr), .R0_data(R0_data)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                        input logic [7:0] m);
    logic [63:0] r = old;
    for (int b = 0; b < 8; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // ---------------- SRAM environment model (1-cycle read latency) ----------
  logic [63:0] sram [longint unsigned];
  always @(posedge clock) begin
    if (W0_en)
      sram[longint'(W0_addr)] = merge(sram.exists(longint'(W0_addr)) ? sram[longint'(W0_addr)] : 64'd0,
                                      W0_data, W0_mask);
    if (R0_en) R0_data <= sram.exists(longint'(R0_addr)) ? sram[longint'(R0_addr)] : 64'd0;
    else       R0_data <= {$urandom(), $urandom()};
  end

  // ---------------- Transaction-level reference model ----------------------
  typedef struct {
    bit          wr;
    bit          err;
    logic [3:0]  id;
    logic [63:0] data;
    int          avail;
  } exp_t;

  exp_t        q[$];
  logic [63:0] ref_mem [longint unsigned];

  bit          exp_ready, exp_valid, fire, flt, stalled_prev;
  longint unsigned word;
  logic [63:0] sv_data;
  logic [3:0]  sv_id;
  logic        sv_wr, sv_err;
  exp_t        e;

  function automatic bit is_fault(input logic [63:0] a);
    return (a < BASE) || (a >= BASE + SPAN) || (a % 8 != 0);
  endfunction

  // Per-cycle checker: outstanding requests = queue size, response becomes
  // visible two cycles after acceptance and leaves on a handshake.
  always @(negedge clock) begin
    if (!reset_n) begin
      chk("rst_req_ready",  req_ready,  0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_data",  resp_data,  0);
      chk("rst_resp_id",    resp_id,    0);
      chk("rst_resp_write", resp_write, 0);
      chk("rst_resp_err",   resp_err,   0);
      chk("rst_W0_en",      W0_en,      0);
      chk("rst_R0_en",      R0_en,      0);
      q.delete();
      stalled_prev = 0;
    end else begin
      exp_ready = (q.size() < DEPTH);
      chk("req_ready", req_ready, exp_ready);
      exp_valid = 0;
      if (q.size() != 0) exp_valid = (q[0].avail <= cyc);
      chk("resp_valid", resp_valid, exp_valid);
      if (exp_valid) begin
        chk("resp_id",    resp_id,    q[0].id);
        chk("resp_write", resp_write, q[0].wr);
        chk("resp_err",   resp_err,   q[0].err);
        chk("resp_data",  resp_data,  q[0].data);
      end
      if (stalled_prev) begin
        chk("stall_id",    resp_id,    sv_id);
        chk("stall_data",  resp_data,  sv_data);
        chk("stall_write", resp_write, sv_wr);
        chk("stall_err",   resp_err,   sv_err);
      end
      stalled_prev = resp_valid && !resp_ready;
      sv_id = resp_id; sv_data = resp_data; sv_wr = resp_write; sv_err = resp_err;

      fire = req_valid && exp_ready;
      flt  = is_fault(req_addr);
      word = (req_addr - BASE) / 8;
      chk("W0_en", W0_en, fire && req_write && !flt);
      chk("R0_en", R0_en, fire && !req_write && !flt);
      if (fire && !flt && req_write) begin
        chk("W0_addr", W0_addr, word);
        chk("W0_data", W0_data, req_data);
        chk("W0_mask", W0_mask, req_mask);
      end
      if (fire && !flt && !req_write) chk("R0_addr", R0_addr, word);

      if (exp_valid && resp_ready) q.pop_front();
      if (fire) begin
        e.wr = req_write; e.err = flt; e.id = req_id; e.avail = cyc + 2; e.data = 64'd0;
        if (!flt && !req_write) e.data = ref_mem.exists(word) ? ref_mem[word] : 64'd0;
        if (!flt && req_write)
          ref_mem[word] = merge(ref_mem.exists(word) ? ref_mem[word] : 64'd0, req_data, req_mask);
        q.push_back(e);
        n_accepted++;
        $display("cyc %0d accept %s addr=%h id=%0d fault=%0d", cyc, req_write ? "WR" : "RD",
                 req_addr, req_id, flt);
      end
    end
  end

  // ---------------- Driver helpers ----------------------------------------
  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic send(input bit wr, input logic [63:0] addr, input logic [63:0] data,
                      input logic [7:0] mask, input logic [3:0] id);
    bit done = 0;
    req_valid = 1; req_write = wr; req_addr = addr; req_data = data; req_mask = mask; req_id = id;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clock);
      if (req_ready === 1'b1) done = 1;
      tick();
    end
    req_valid = 0;
    chk("send_accepted", done, 1);
  endtask

  task automatic expect_resp(input string tag, input logic [3:0] id, input bit err,
                             input logic [63:0] data);
    bit seen = 0;
    for (int i = 0; i < 32 && !seen; i++) begin
      @(negedge clock);
      if (resp_valid === 1'b1 && resp_id === id) begin
        seen = 1;
        chk({tag, "_err"},  resp_err,  err);
        chk({tag, "_data"}, resp_data, data);
      end
    end
    chk({tag, "_seen"}, seen, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && q.size() != 0; i++) tick();
    chk("drain_empty", q.size(), 0);
  endtask

  // Watchdog: never hang.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- Directed steps then random traffic --------------------
  initial begin
    int acc0;
    reset_n = 0; req_valid = 0; req_write = 0; req_addr = 0; req_data = 0;
    req_mask = 0; req_id = 0; resp_ready = 1;
    repeat (3) tick();
    reset_n = 1;
    @(negedge clock);
    chk("first_ready_after_reset", req_ready, 1);
    tick();

    // 1: write then read word 0
    send(1, BASE, 64'h1122334455667788, 8'hFF, 4'd1);
    send(0, BASE, 64'd0, 8'h00, 4'd2);
    expect_resp("t1_read", 4'd2, 0, 64'h1122334455667788);
    drain();

    // 2: masked partial write over a zeroed word
    send(1, BASE + 8, 64'd0, 8'hFF, 4'd5);
    send(1, BASE + 8, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 4'd6);
    send(0, BASE + 8, 64'd0, 8'h00, 4'd7);
    expect_resp("t2_read", 4'd7, 0, 64'h0000_0000_FFFF_FFFF);
    drain();

    // 3: address faults
    send(0, 64'h7FFF_FFF8, 64'd0, 8'h00, 4'd3);
    expect_resp("t3_below", 4'd3, 1, 64'd0);
    send(0, 64'h8000_0004, 64'd0, 8'h00, 4'd4);
    expect_resp("t3_misalign", 4'd4, 1, 64'd0);
    drain();

    // 4: credit limit with the consumer stalled
    resp_ready = 0;
    acc0 = n_accepted;
    for (int i = 0; i < 6; i++) begin
      req_valid = 1; req_write = 0; req_addr = BASE + 64'(8 * i); req_id = 4'(i);
      tick();
    end
    req_valid = 0;
    chk("t4_accepted", n_accepted - acc0, 4);
    @(negedge clock);
    chk("t4_ready_low", req_ready, 0);
    repeat (4) tick();
    resp_ready = 1;
    drain();

    // 5: full-rate streaming
    for (int i = 0; i < 8; i++) begin
      req_valid = 1; req_write = 0; req_addr = BASE + 64'(8 * i); req_id = 4'(i);
      @(negedge clock);
      chk("t5_ready", req_ready, 1);
      tick();
    end
    req_valid = 0;
    drain();

    // 6: reset with responses pending
    resp_ready = 0;
    for (int i = 0; i < 3; i++) send(0, BASE + 64'(8 * i), 64'd0, 8'h00, 4'(10 + i));
    repeat (3) tick();
    #1 reset_n = 0;
    #1 chk("t6_resp_valid_in_reset", resp_valid, 0);
    chk("t6_ready_in_reset", req_ready, 0);
    tick(); tick();
    reset_n = 1;
    resp_ready = 1;
    send(0, BASE + 8, 64'd0, 8'h00, 4'd9);
    expect_resp("t6_own_resp", 4'd9, 0, 64'h0000_0000_FFFF_FFFF);
    repeat (5) tick();
    drain();

    // Random traffic with random backpressure and boundary addresses
    for (int i = 0; i < 600; i++) begin
      req_valid  = ($urandom_range(0, 9) < 7);
      req_write  = $urandom_range(0, 1) == 1;
      req_data   = {$urandom(), $urandom()};
      req_mask   = 8'($urandom());
      req_id     = 4'($urandom());
      resp_ready = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 9))
        0:       req_addr = BASE - 8;
        1:       req_addr = BASE + 64'(8 * $urandom_range(0, 15)) + 64'($urandom_range(1, 7));
        2:       req_addr = BASE + SPAN;
        3:       req_addr = BASE + SPAN - 8;
        default: req_addr = BASE + 64'(8 * $urandom_range(0, 15));
      endcase
      tick();
    end
    req_valid = 0;
    resp_ready = 1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
